// File: rtl/sum_unit_pipe.sv
// Pipelined add/sub mantissa adder: the carry chain is cut into NUM_STAGE registered segments.
// Define SUM_PIPE_FLAG_EN to add the registered o_zero / o_ovf result flags.
module sum_unit_pipe #(
    parameter int SIZE_DATA = 28,
    parameter int NUM_STAGE = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_sub,
    input  logic                 i_carry,
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_sum,
    output logic                 o_carry
`ifdef SUM_PIPE_FLAG_EN
    ,
    output logic                 o_zero,
    output logic                 o_ovf
`endif
);

    localparam int SEG  = (SIZE_DATA + NUM_STAGE - 1) / NUM_STAGE;
    localparam int LAST = NUM_STAGE - 1;

    logic                                en;
    logic [NUM_STAGE-1:0]                v_q;
    logic [NUM_STAGE-1:0][SIZE_DATA-1:0] a_in, bx_in, sum_in, sum_d;
    logic [NUM_STAGE-1:0][SIZE_DATA-1:0] a_q, bx_q, sum_q;
    logic [NUM_STAGE-1:0]                c_in, c_d, c_q;

    assign en      = ~v_q[LAST] | i_ready;
    assign o_ready = en & ~i_rst;

    generate
        for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
            localparam int LO = k * SEG;
            localparam int W  = (LO >= SIZE_DATA) ? 0 :
                                ((SIZE_DATA - LO < SEG) ? SIZE_DATA - LO : SEG);

            if (k == 0) begin : g_head
                // Subtract is A + ~B + ~borrow, so the carry-in becomes sub ^ cin.
                assign a_in[k]   = i_data_a;
                assign bx_in[k]  = i_sub ? ~i_data_b : i_data_b;
                assign c_in[k]   = i_sub ^ i_carry;
                assign sum_in[k] = '0;
            end else begin : g_body
                assign a_in[k]   = a_q[k-1];
                assign bx_in[k]  = bx_q[k-1];
                assign c_in[k]   = c_q[k-1];
                assign sum_in[k] = sum_q[k-1];
            end

            if (W == 0) begin : g_empty
                assign sum_d[k] = sum_in[k];
                assign c_d[k]   = c_in[k];
            end else begin : g_add
                localparam logic [SIZE_DATA-1:0] MASK = SIZE_DATA'({W{1'b1}}) << LO;
                logic [W:0] seg;

                assign seg      = {1'b0, a_in[k][LO +: W]} + {1'b0, bx_in[k][LO +: W]}
                                + (W+1)'(c_in[k]);
                assign sum_d[k] = (sum_in[k] & ~MASK) | (SIZE_DATA'(seg[W-1:0]) << LO);
                assign c_d[k]   = seg[W];
            end
        end
    endgenerate

    // Inner data registers are never reset; only valid bits and the output stage are.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_q         <= '0;
            sum_q[LAST] <= '0;
            c_q[LAST]   <= 1'b0;
        end else if (en) begin
            v_q   <= (v_q << 1) | NUM_STAGE'(i_valid);
            a_q   <= a_in;
            bx_q  <= bx_in;
            sum_q <= sum_d;
            c_q   <= c_d;
        end
    end

    assign o_valid = v_q[LAST];
    assign o_sum   = sum_q[LAST];
    assign o_carry = c_q[LAST];

`ifdef SUM_PIPE_FLAG_EN
    localparam int MSB = SIZE_DATA - 1;

    logic zero_q, ovf_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en) begin
            zero_q <= (sum_d[LAST] == '0);
            ovf_q  <= (a_in[LAST][MSB] == bx_in[LAST][MSB]) &
                      (sum_d[LAST][MSB] != a_in[LAST][MSB]);
        end
    end

    assign o_zero = zero_q;
    assign o_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sum_unit_pipe.sv
// Directed and scoreboarded random bench for sum_unit_pipe (NUM_STAGE 2 directed; 1, 3, 28 random).
// Flag checks are compiled in when SUM_PIPE_FLAG_EN is defined.
module tb_sum_unit_pipe;

    localparam int SD = 28;
    localparam int NS = 2;

    typedef struct packed {
        logic          sub;
        logic          cin;
        logic [SD-1:0] a;
        logic [SD-1:0] b;
        logic [SD-1:0] sum;
        logic          carry;
        logic          zero;
        logic          ovf;
    } vec_t;

    // sub cin a b -> sum carry zero ovf, all hand-computed
    vec_t vecs [8] = '{
        '{1'b0, 1'b0, 28'hFFFFFFF, 28'h0000001, 28'h0000000, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b0, 28'h0000005, 28'h0000007, 28'hFFFFFFE, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b1, 28'h0000005, 28'h0000007, 28'hFFFFFFD, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 28'h0003FFF, 28'h0000001, 28'h0004000, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 28'h0000007, 28'h0000005, 28'h0000002, 1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b0, 28'h8000000, 28'h8000000, 28'h0000000, 1'b1, 1'b1, 1'b1},
        '{1'b1, 1'b0, 28'h1234567, 28'h1234567, 28'h0000000, 1'b1, 1'b1, 1'b0},
        '{1'b0, 1'b0, 28'h7FFFFFF, 28'h0000001, 28'h8000000, 1'b0, 1'b0, 1'b1}
    };

    vec_t stream [6] = '{
        '{1'b0, 1'b0, 28'h0000010, 28'h0000020, 28'h0000030, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFF, 1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b0, 28'h0000100, 28'h0000001, 28'h00000FF, 1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b1, 28'h0000000, 28'h0000000, 28'hFFFFFFF, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 28'h0004000, 28'h0003FFF, 28'h0008000, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 28'hABCDEF0, 28'h1234567, 28'h9999989, 1'b1, 1'b0, 1'b0}
    };

    logic          clk = 1'b0;
    logic          rst, i_valid, i_sub, i_cin, i_ready;
    logic [SD-1:0] i_a, i_b;
    logic          o_ready, o_valid, o_carry;
    logic [SD-1:0] o_sum;
`ifdef SUM_PIPE_FLAG_EN
    logic          o_zero, o_ovf;
`endif

    logic          rv, rsub, rcin, rrdy, rnd_on;
    logic [SD-1:0] ra, rb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, zero, carry, sum} from plain integer arithmetic
    function automatic logic [SD+2:0] model(input logic sub, input logic cin,
                                            input logic [SD-1:0] a, input logic [SD-1:0] b);
        logic [SD:0]   r;
        logic [SD-1:0] bb;
        if (!sub) begin
            r = {1'b0, a} + {1'b0, b} + (SD+1)'(cin);
        end else begin
            r[SD-1:0] = a - b - SD'(cin);
            r[SD]     = ({1'b0, a} >= ({1'b0, b} + (SD+1)'(cin)));
        end
        bb = sub ? ~b : b;
        return {(a[SD-1] == bb[SD-1]) && (r[SD-1] != a[SD-1]), r[SD-1:0] == '0, r};
    endfunction

    sum_unit_pipe #(.SIZE_DATA(SD), .NUM_STAGE(NS)) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sub    (i_sub),
        .i_carry  (i_cin),
        .i_data_a (i_a),
        .i_data_b (i_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
        .o_carry  (o_carry)
`ifdef SUM_PIPE_FLAG_EN
        ,
        .o_zero   (o_zero),
        .o_ovf    (o_ovf)
`endif
    );

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int RNS = (g == 0) ? 1 : ((g == 1) ? 3 : 28);
        logic          ordy, ov, oc;
        logic [SD-1:0] os;
`ifdef SUM_PIPE_FLAG_EN
        logic          oz, oo;
`endif
        logic [SD+2:0] sbq[$];
        logic [SD+2:0] exp_v;
        int            n_acc = 0;

        sum_unit_pipe #(.SIZE_DATA(SD), .NUM_STAGE(RNS)) u_rnd (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_valid  (rv),
            .o_ready  (ordy),
            .i_sub    (rsub),
            .i_carry  (rcin),
            .i_data_a (ra),
            .i_data_b (rb),
            .o_valid  (ov),
            .i_ready  (rrdy),
            .o_sum    (os),
            .o_carry  (oc)
`ifdef SUM_PIPE_FLAG_EN
            ,
            .o_zero   (oz),
            .o_ovf    (oo)
`endif
        );

        always @(negedge clk) begin
            if (rnd_on) begin
                if (ov && rrdy) begin
                    if (sbq.size() == 0) begin
                        check_eq($sformatf("rnd_ns%0d_unexpected", RNS), 64'(sbq.size()), 64'(1));
                    end else begin
                        exp_v = sbq.pop_front();
`ifdef SUM_PIPE_FLAG_EN
                        check_eq($sformatf("rnd_ns%0d", RNS), 64'({oo, oz, oc, os}), 64'(exp_v));
`else
                        check_eq($sformatf("rnd_ns%0d", RNS), 64'({oc, os}), 64'(exp_v[SD:0]));
`endif
                    end
                end
                if (rv && ordy) begin
                    sbq.push_back(model(rsub, rcin, ra, rb));
                    n_acc++;
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        i_sub = v.sub;
        i_cin = v.cin;
        i_a   = v.a;
        i_b   = v.b;
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int lat;
        @(posedge clk); #1;
        drive(v);
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        check_eq($sformatf("v%0d_ready", idx), 64'(o_ready), 64'(1));
        lat = 0;
        do begin
            @(posedge clk); #1;
            i_valid = 1'b0;
            lat++;
            @(negedge clk);
        end while (!o_valid && lat < 10);
        check_eq($sformatf("v%0d_latency", idx), 64'(lat), 64'(NS));
        check_eq($sformatf("v%0d_sum", idx), 64'(o_sum), 64'(v.sum));
        check_eq($sformatf("v%0d_carry", idx), 64'(o_carry), 64'(v.carry));
`ifdef SUM_PIPE_FLAG_EN
        check_eq($sformatf("v%0d_zero", idx), 64'(o_zero), 64'(v.zero));
        check_eq($sformatf("v%0d_ovf", idx), 64'(o_ovf), 64'(v.ovf));
`endif
    endtask

    task automatic run_stream();
        int          in_i = 0, out_i = 0, stall_cnt = 0, cyc = 0;
        bit          stalled = 1'b0, acc = 1'b0, first = 1'b0;
        logic [SD:0] held = '0;
        i_ready = 1'b1;
        while (out_i < 6 && cyc < 80) begin
            @(posedge clk); #1;
            if (acc) in_i++;
            if (stall_cnt > 0) stall_cnt--;
            i_ready = (stall_cnt == 0);
            i_valid = (in_i < 6);
            if (in_i < 6) drive(stream[in_i]);
            @(negedge clk);
            first = 1'b0;
            if (!stalled && o_valid) begin
                stalled   = 1'b1;
                stall_cnt = 3;
                held      = {o_carry, o_sum};
                i_ready   = 1'b0;
                first     = 1'b1;
                #1;
            end
            if (stall_cnt > 0) begin
                check_eq("stall_ready", 64'(o_ready), 64'(0));
                if (!first) check_eq("stall_hold", 64'({o_carry, o_sum}), 64'(held));
            end
            acc = i_valid && o_ready;
            if (o_valid && i_ready) begin
                check_eq($sformatf("s%0d_sum", out_i), 64'(o_sum), 64'(stream[out_i].sum));
                check_eq($sformatf("s%0d_carry", out_i), 64'(o_carry), 64'(stream[out_i].carry));
                out_i++;
            end
            cyc++;
        end
        check_eq("stream_count", 64'(out_i), 64'(6));
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    task automatic run_reset();
        @(posedge clk); #1;
        drive(stream[1]);
        i_valid = 1'b1;
        i_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_acc0", 64'(o_ready), 64'(1));
        @(posedge clk); #1;
        drive(stream[2]);
        @(negedge clk);
        check_eq("rst_acc1", 64'(o_ready), 64'(1));
        @(posedge clk); #1;
        i_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check_eq("rst_ready_low", 64'(o_ready), 64'(0));
        @(posedge clk); #1;
        rst     = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        check_eq("rst_valid", 64'(o_valid), 64'(0));
        check_eq("rst_sum", 64'(o_sum), 64'(0));
        check_eq("rst_carry", 64'(o_carry), 64'(0));
`ifdef SUM_PIPE_FLAG_EN
        check_eq("rst_zero", 64'(o_zero), 64'(0));
        check_eq("rst_ovf", 64'(o_ovf), 64'(0));
`endif
        check_eq("rst_release_ready", 64'(o_ready), 64'(1));
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("rst_flush", 64'(o_valid), 64'(0));
        end
    endtask

    task automatic run_random();
        rnd_on = 1'b1;
        for (int cyc = 0; cyc < 6000 &&
             (g_rnd[0].n_acc < 500 || g_rnd[1].n_acc < 500 || g_rnd[2].n_acc < 500); cyc++) begin
            @(posedge clk); #1;
            rv   = ($urandom_range(0, 3) != 0);
            rrdy = ($urandom_range(0, 3) != 0);
            rsub = 1'($urandom);
            rcin = 1'($urandom);
            ra   = ($urandom_range(0, 7) == 0) ? '1 : SD'($urandom);
            rb   = ($urandom_range(0, 7) == 0) ? '0 : SD'($urandom);
        end
        @(posedge clk); #1;
        rv   = 1'b0;
        rrdy = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_eq("rnd_ns1_ops", 64'(g_rnd[0].n_acc >= 500), 64'(1));
        check_eq("rnd_ns3_ops", 64'(g_rnd[1].n_acc >= 500), 64'(1));
        check_eq("rnd_ns28_ops", 64'(g_rnd[2].n_acc >= 500), 64'(1));
        check_eq("rnd_ns1_left", 64'(g_rnd[0].sbq.size()), 64'(0));
        check_eq("rnd_ns3_left", 64'(g_rnd[1].sbq.size()), 64'(0));
        check_eq("rnd_ns28_left", 64'(g_rnd[2].sbq.size()), 64'(0));
        rnd_on = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_sub   = 1'b0;
        i_cin   = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_ready = 1'b1;
        rv      = 1'b0;
        rsub    = 1'b0;
        rcin    = 1'b0;
        ra      = '0;
        rb      = '0;
        rrdy    = 1'b1;
        rnd_on  = 1'b0;

        @(posedge clk);
        @(negedge clk);
        check_eq("init_valid", 64'(o_valid), 64'(0));
        check_eq("init_sum", 64'(o_sum), 64'(0));
        check_eq("init_carry", 64'(o_carry), 64'(0));
        check_eq("init_ready", 64'(o_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("init_release_ready", 64'(o_ready), 64'(1));

        for (int i = 0; i < 8; i++) run_op(vecs[i], i);
        run_stream();
        run_reset();
        run_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
